// File: rtl/x_ramb16_spx_int.sv
// Single-port 16Kb block RAM: per-lane writes, selectable write mode, optional output
// register; GSR loads INIT into the output path, SSR loads SRVAL.
module x_ramb16_spx_int #(
   parameter int unsigned DATA_WIDTH = 1,
   parameter string WRITE_MODE = "WRITE_FIRST",
   parameter int unsigned DO_REG = 0,
   parameter logic [DATA_WIDTH-1:0] INIT = '0,
   parameter logic [DATA_WIDTH-1:0] SRVAL = '0,
   localparam int unsigned ADDR_WIDTH = (DATA_WIDTH == 1) ? 14 :
                                        (DATA_WIDTH == 2) ? 13 :
                                        (DATA_WIDTH == 4) ? 12 :
                                        (DATA_WIDTH == 9) ? 11 :
                                        (DATA_WIDTH == 18) ? 10 : 9,
   localparam int unsigned NUM_LANES = (DATA_WIDTH >= 9) ? DATA_WIDTH / 9 : 1
) (
   input  logic                  CLK,
   input  logic                  GSR,
   input  logic [ADDR_WIDTH-1:0] ADDR,
   input  logic [DATA_WIDTH-1:0] DI,
   output logic [DATA_WIDTH-1:0] DO,
   input  logic                  EN,
   input  logic                  SSR,
   input  logic [NUM_LANES-1:0]  WE,
   input  logic                  REGCE
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
   localparam int unsigned MODE_WF = 0;
   localparam int unsigned MODE_RF = 1;
   localparam int unsigned MODE = (WRITE_MODE == "READ_FIRST") ? 1 :
                                  (WRITE_MODE == "NO_CHANGE")  ? 2 : MODE_WF;

   localparam bit DW_OK = (DATA_WIDTH == 1) || (DATA_WIDTH == 2) || (DATA_WIDTH == 4) ||
                          (DATA_WIDTH == 9) || (DATA_WIDTH == 18) || (DATA_WIDTH == 36);
   localparam bit WM_OK = (WRITE_MODE == "WRITE_FIRST") || (WRITE_MODE == "READ_FIRST") ||
                          (WRITE_MODE == "NO_CHANGE");

   // Reject illegal configurations before simulation starts
   if (!DW_OK) begin : g_bad_data_width
      $fatal(1, "x_ramb16_spx_int: illegal DATA_WIDTH %0d", DATA_WIDTH);
   end
   if (!WM_OK) begin : g_bad_write_mode
      $fatal(1, "x_ramb16_spx_int: illegal WRITE_MODE %s", WRITE_MODE);
   end

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] latch_q;
   logic [DATA_WIDTH-1:0] out_q;
   logic [DATA_WIDTH-1:0] we_mask;
   logic [DATA_WIDTH-1:0] rd_word;
   logic [DATA_WIDTH-1:0] wr_word;
   logic                  any_we;

   // Expand per-lane write enables to a bit mask; narrow widths have one lane
   if (DATA_WIDTH < 9) begin : g_one_lane
      assign we_mask = {DATA_WIDTH{WE[0]}};
   end else begin : g_lanes
      for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
         assign we_mask[9*i +: 9] = {9{WE[i]}};
      end
   end

   always_comb begin
      rd_word = mem[ADDR];
      wr_word = (DI & we_mask) | (rd_word & ~we_mask);
      any_we  = |WE;
   end

   // Storage, latch stage and output register; GSR freezes all of them
   always_ff @(posedge CLK or posedge GSR) begin
      if (GSR) begin
         latch_q <= INIT;
         out_q   <= INIT;
      end else begin
         if (EN && any_we) begin
            mem[ADDR] <= wr_word;
         end
         if (EN) begin
            if (SSR) begin
               latch_q <= SRVAL;
            end else if (!any_we || MODE == MODE_RF) begin
               latch_q <= rd_word;
            end else if (MODE == MODE_WF) begin
               latch_q <= wr_word;
            end
         end
         if (REGCE) begin
            out_q <= SSR ? SRVAL : latch_q;
         end
      end
   end

   assign DO = (DO_REG != 0) ? out_q : latch_q;

endmodule

// File: tb/tb_x_ramb16_spx_int.sv
// Bench for x_ramb16_spx_int: four configurations on a shared clock and GSR, checked
// against an array-based model, with directed corner scenarios then random traffic.
module tb_x_ramb16_spx_int;

   logic CLK = 1'b0;
   logic GSR = 1'b0;
   always #5 CLK = ~CLK;

   logic [35:0] di_s    [4];
   logic [13:0] addr_s  [4];
   logic [3:0]  we_s    [4];
   logic        en_s    [4];
   logic        ssr_s   [4];
   logic        regce_s [4];

   logic [35:0] do36;
   logic [8:0]  do9;
   logic [3:0]  do4;
   logic [17:0] do18;

   // 0: 36b write-first, 1: 9b read-first with INIT, 2: 4b no-change, 3: 18b registered
   localparam int          DW    [4] = '{36, 9, 4, 18};
   localparam int          MODE  [4] = '{0, 1, 2, 0};
   localparam bit          DOREG [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic [35:0] SRV   [4] = '{36'h1_2345_6789, 36'h0F0, 36'hA, 36'h2AAAA};
   localparam logic [35:0] INI   [4] = '{36'h0, 36'h155, 36'h0, 36'h0};

   x_ramb16_spx_int #(.DATA_WIDTH(36), .WRITE_MODE("WRITE_FIRST"), .DO_REG(0),
                      .SRVAL(36'h1_2345_6789)) u36 (
      .CLK(CLK), .GSR(GSR), .ADDR(addr_s[0][8:0]), .DI(di_s[0]), .DO(do36),
      .EN(en_s[0]), .SSR(ssr_s[0]), .WE(we_s[0]), .REGCE(regce_s[0]));

   x_ramb16_spx_int #(.DATA_WIDTH(9), .WRITE_MODE("READ_FIRST"), .DO_REG(0),
                      .INIT(9'h155), .SRVAL(9'h0F0)) u9 (
      .CLK(CLK), .GSR(GSR), .ADDR(addr_s[1][10:0]), .DI(di_s[1][8:0]), .DO(do9),
      .EN(en_s[1]), .SSR(ssr_s[1]), .WE(we_s[1][0:0]), .REGCE(regce_s[1]));

   x_ramb16_spx_int #(.DATA_WIDTH(4), .WRITE_MODE("NO_CHANGE"), .DO_REG(0),
                      .SRVAL(4'hA)) u4 (
      .CLK(CLK), .GSR(GSR), .ADDR(addr_s[2][11:0]), .DI(di_s[2][3:0]), .DO(do4),
      .EN(en_s[2]), .SSR(ssr_s[2]), .WE(we_s[2][0:0]), .REGCE(regce_s[2]));

   x_ramb16_spx_int #(.DATA_WIDTH(18), .WRITE_MODE("WRITE_FIRST"), .DO_REG(1),
                      .SRVAL(18'h2AAAA)) u18 (
      .CLK(CLK), .GSR(GSR), .ADDR(addr_s[3][9:0]), .DI(di_s[3][17:0]), .DO(do18),
      .EN(en_s[3]), .SSR(ssr_s[3]), .WE(we_s[3][1:0]), .REGCE(regce_s[3]));

   // Reference state: the traffic only touches addresses 0..15
   logic [35:0] mem_m [4][16];
   logic [35:0] lat_m [4];
   logic [35:0] out_m [4];

   int n_cmp = 0;
   int n_mis = 0;

   function automatic logic [35:0] full(input int k);
      logic [35:0] one = 36'd1;
      return (one << DW[k]) - one;
   endfunction

   function automatic logic [35:0] lane_mask(input int k, input logic [3:0] we);
      logic [35:0] m = '0;
      if (DW[k] < 9) return we[0] ? full(k) : 36'h0;
      for (int i = 0; i < DW[k] / 9; i++)
         if (we[i]) m = m | (36'h1FF << (9 * i));
      return m;
   endfunction

   function automatic logic [35:0] get_do(input int k);
      case (k)
         0:       return do36;
         1:       return 36'(do9);
         2:       return 36'(do4);
         default: return 36'(do18);
      endcase
   endfunction

   task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      for (int k = 0; k < 4; k++)
         check($sformatf("%s_u%0d", tag, k), get_do(k), DOREG[k] ? out_m[k] : lat_m[k]);
   endtask

   // One clock edge of the reference, from the inputs currently applied
   task automatic model_edge();
      logic [35:0] m;
      logic [35:0] old;
      logic [35:0] lat_pre;
      logic [3:0]  a;
      if (GSR) return;
      for (int k = 0; k < 4; k++) begin
         a       = addr_s[k][3:0];
         m       = lane_mask(k, we_s[k]);
         old     = mem_m[k][a];
         lat_pre = lat_m[k];
         if (en_s[k]) begin
            if (m != 0) mem_m[k][a] = (di_s[k] & m) | (old & ~m);
            if (ssr_s[k])       lat_m[k] = SRV[k];
            else if (m == 0)    lat_m[k] = old;
            else if (MODE[k] == 0) lat_m[k] = (di_s[k] & m) | (old & ~m);
            else if (MODE[k] == 1) lat_m[k] = old;
         end
         if (DOREG[k] && regce_s[k]) out_m[k] = ssr_s[k] ? SRV[k] : lat_pre;
      end
   endtask

   task automatic gsr_model();
      for (int k = 0; k < 4; k++) begin
         lat_m[k] = INI[k];
         out_m[k] = INI[k];
      end
   endtask

   task automatic tick(input string tag);
      model_edge();
      @(posedge CLK);
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      for (int k = 0; k < 4; k++) begin
         di_s[k] = '0; addr_s[k] = '0; we_s[k] = '0;
         en_s[k] = 1'b0; ssr_s[k] = 1'b0; regce_s[k] = 1'b0;
      end
   endtask

   initial begin
      idle();
      // Power-up GSR pulse
      #1 GSR = 1'b1;
      gsr_model();
      #1 check_all("reset");
      @(negedge CLK);
      GSR = 1'b0;

      // Give every instance known contents at addresses 0..15
      for (int a = 0; a < 16; a++) begin
         for (int k = 0; k < 4; k++) begin
            en_s[k] = 1'b1; regce_s[k] = 1'b1; we_s[k] = 4'hF;
            addr_s[k] = 14'(a);
            di_s[k] = 36'({$urandom, $urandom}) & full(k);
         end
         tick("prefill");
      end

      // Lane-selective write-first on the 36-bit instance
      idle();
      en_s[0] = 1'b1; we_s[0] = 4'hF; addr_s[0] = 14'd5; di_s[0] = 36'hF_FFFF_FFFF;
      tick("w36_full");
      we_s[0] = 4'b0101; di_s[0] = 36'h0;
      tick("w36_lanes");
      check("do36_lanes", do36, 36'hF_F803_FE00);
      we_s[0] = 4'h0;
      tick("r36");
      check("do36_reread", do36, 36'hF_F803_FE00);

      // Read-first returns the old word on the write edge
      idle();
      en_s[1] = 1'b1; we_s[1] = 4'h1; addr_s[1] = 14'd3; di_s[1] = 36'h1AA;
      tick("w9_first");
      di_s[1] = 36'h055;
      tick("w9_second");
      check("do9_read_first", 36'(do9), 36'h1AA);
      we_s[1] = 4'h0;
      tick("r9");
      check("do9_reread", 36'(do9), 36'h055);

      // No-change holds the latch across a write
      idle();
      en_s[2] = 1'b1; we_s[2] = 4'h1; addr_s[2] = 14'd7; di_s[2] = 36'hC;
      tick("w4_7");
      we_s[2] = 4'h0;
      tick("r4_7");
      check("do4_read7", 36'(do4), 36'hC);
      we_s[2] = 4'h1; addr_s[2] = 14'd9; di_s[2] = 36'h3;
      tick("w4_9");
      check("do4_hold", 36'(do4), 36'hC);
      we_s[2] = 4'h0;
      tick("r4_9");
      check("do4_read9", 36'(do4), 36'h3);

      // Output register: two-edge latency, REGCE freeze, SSR into the register
      idle();
      en_s[3] = 1'b1; regce_s[3] = 1'b1; we_s[3] = 4'h3; addr_s[3] = 14'd2; di_s[3] = 36'h12345;
      tick("w18_2");
      addr_s[3] = 14'd4; di_s[3] = 36'h0ABCD;
      tick("w18_4");
      we_s[3] = 4'h0; addr_s[3] = 14'd2;
      tick("r18_e1");
      check("do18_edge1", 36'(do18), 36'h0ABCD);
      en_s[3] = 1'b0;
      tick("r18_e2");
      check("do18_edge2", 36'(do18), 36'h12345);
      en_s[3] = 1'b1; regce_s[3] = 1'b0; addr_s[3] = 14'd4;
      tick("r18_frz1");
      check("do18_frozen1", 36'(do18), 36'h12345);
      tick("r18_frz2");
      check("do18_frozen2", 36'(do18), 36'h12345);
      en_s[3] = 1'b0; regce_s[3] = 1'b1; ssr_s[3] = 1'b1;
      tick("ssr18");
      check("do18_srval", 36'(do18), 36'h2AAAA);

      // GSR between edges with a write pending: output to INIT, write dropped
      idle();
      en_s[1] = 1'b1; we_s[1] = 4'h1; addr_s[1] = 14'd3; di_s[1] = 36'h0AB;
      #2 GSR = 1'b1;
      gsr_model();
      #1 check("do9_gsr_async", 36'(do9), 36'h155);
      check_all("gsr_async");
      tick("gsr_hold1");
      tick("gsr_hold2");
      check("do9_gsr_hold", 36'(do9), 36'h155);
      GSR = 1'b0;
      we_s[1] = 4'h0;
      tick("r9_after_gsr");
      check("do9_after_gsr", 36'(do9), 36'h055);

      // Random traffic with frequent address collisions
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 4; k++) begin
            en_s[k]    = ($urandom % 4) != 0;
            ssr_s[k]   = ($urandom % 8) == 0;
            regce_s[k] = ($urandom % 4) != 0;
            addr_s[k]  = 14'($urandom % 16);
            we_s[k]    = 4'($urandom) & ((DW[k] >= 9) ? 4'((1 << (DW[k] / 9)) - 1) : 4'h1);
            if ($urandom % 3 == 0) we_s[k] = 4'h0;
            di_s[k]    = 36'({$urandom, $urandom}) & full(k);
         end
         tick("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
